// File: rtl/dmem_mmio_pkg.sv
`default_nettype none
//==============================================================================
// Package  : riscv_mem_pkg
// Brief    : Address map, store-size codes, UART state type and STATUS layout
// Revision : 1.0
//==============================================================================
package riscv_mem_pkg;

  localparam logic [31:0] MMIO_BASE  = 32'h8000_0000;
  localparam logic [3:0]  OFF_TXDATA = 4'h0;
  localparam logic [3:0]  OFF_STATUS = 4'h4;
  localparam logic [3:0]  OFF_TIMER  = 4'h8;

  localparam logic [1:0]  SZ_BYTE = 2'b00;
  localparam logic [1:0]  SZ_HALF = 2'b01;
  localparam logic [1:0]  SZ_WORD = 2'b10;

  localparam int STAT_FULL  = 0;
  localparam int STAT_BUSY  = 1;
  localparam int STAT_OVF   = 2;
  localparam int STAT_COUNT = 4;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uartState_t;

  // Byte-lane enables for a store of the given size at the given lane.
  function automatic logic [3:0] laneMask(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001 << lane;
      SZ_HALF: m = lane[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_mmio_if.sv
`default_nettype none
//==============================================================================
// Interface : dmem_mmio_if
// Brief     : M-stage data-memory bus between the core and the memory/MMIO stage
// Revision  : 1.0
//==============================================================================
interface dmem_mmio_if;
  logic        MemWriteM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [1:0]  InstrM;
  logic [31:0] ReadDataM;

  modport master (
    output MemWriteM,
    output ALUResultM,
    output WriteDataM,
    output InstrM,
    input  ReadDataM
  );

  modport slave (
    input  MemWriteM,
    input  ALUResultM,
    input  WriteDataM,
    input  InstrM,
    output ReadDataM
  );
endinterface
`default_nettype wire

// File: rtl/dmem_mmio_uart.sv
`default_nettype none
//==============================================================================
// Module   : uart_tx_unit
// Brief    : UART transmitter, TX FIFO feeding an 8N1 frame FSM with baud counter
// Revision : 1.0
//==============================================================================
module uart_tx_unit
  import riscv_mem_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int TXFIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            push,
  input  logic [7:0]                      din,
  output logic                            full,
  output logic [$clog2(TXFIFO_DEPTH):0]   count,
  output logic                            busy,
  output logic                            tx
);

  localparam int c_PTR_W  = $clog2(TXFIFO_DEPTH);
  localparam int c_BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [c_PTR_W:0]    c_FULL      = (c_PTR_W + 1)'(TXFIFO_DEPTH);

  logic [7:0]          r_fifo [TXFIFO_DEPTH];
  logic [c_PTR_W-1:0]  r_wrPtr;
  logic [c_PTR_W-1:0]  r_rdPtr;
  logic [c_PTR_W:0]    r_count;
  uartState_t          r_state;
  logic [c_BAUD_W-1:0] r_baud;
  logic [2:0]          r_bitCnt;
  logic [7:0]          r_shift;
  logic                r_tx;

  logic w_pushOk;
  logic w_pop;
  logic w_baudDone;

  // Fullness is judged on the registered count, so a same-cycle pop never frees a slot.
  assign w_pushOk   = push && (r_count != c_FULL);
  assign w_pop      = (r_state == UART_IDLE) && (r_count != '0);
  assign w_baudDone = (r_baud == c_BAUD_LAST);

  assign full  = (r_count == c_FULL);
  assign count = r_count;
  assign busy  = (r_count != '0) || (r_state != UART_IDLE);
  assign tx    = r_tx;

  always_ff @(posedge clk) begin
    if (w_pushOk) begin
      r_fifo[r_wrPtr] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr  <= '0;
      r_rdPtr  <= '0;
      r_count  <= '0;
      r_state  <= UART_IDLE;
      r_baud   <= '0;
      r_bitCnt <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
    end else begin
      if (w_pushOk) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end

      case ({w_pushOk, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      case (r_state)
        UART_IDLE: begin
          r_tx     <= 1'b1;
          r_baud   <= '0;
          r_bitCnt <= '0;
          if (w_pop) begin
            r_shift <= r_fifo[r_rdPtr];
            r_rdPtr <= r_rdPtr + 1'b1;
            r_tx    <= 1'b0;
            r_state <= UART_START;
          end
        end
        UART_START: begin
          if (w_baudDone) begin
            r_baud  <= '0;
            r_tx    <= r_shift[0];
            r_state <= UART_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        UART_DATA: begin
          if (w_baudDone) begin
            r_baud <= '0;
            if (r_bitCnt == 3'd7) begin
              r_bitCnt <= '0;
              r_tx     <= 1'b1;
              r_state  <= UART_STOP;
            end else begin
              // Shift first, so the next bit always sits at r_shift[1] here.
              r_bitCnt <= r_bitCnt + 1'b1;
              r_shift  <= {1'b0, r_shift[7:1]};
              r_tx     <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        UART_STOP: begin
          if (w_baudDone) begin
            r_baud  <= '0;
            r_state <= UART_IDLE;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          r_state <= UART_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_mmio.sv
`default_nettype none
//==============================================================================
// Module   : dmem_mmio
// Brief    : Data memory stage: word RAM with byte-lane stores plus UART/timer MMIO
// Revision : 1.0
//==============================================================================
module dmem_mmio
  import riscv_mem_pkg::*;
#(
  parameter int RAM_WORDS    = 256,
  parameter int CLKS_PER_BIT = 16,
  parameter int TXFIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  dmem_mmio_if.slave   bus,
  output logic         uart_tx
);

  localparam int c_IDX_W = $clog2(RAM_WORDS);
  localparam int c_CNT_W = $clog2(TXFIFO_DEPTH) + 1;

  logic [31:0]        r_ram [RAM_WORDS];
  logic [31:0]        r_timer;
  logic               r_ovf;

  logic [c_IDX_W-1:0] w_idx;
  logic               w_isMmio;
  logic [3:0]         w_off;
  logic               w_wrRam;
  logic               w_wrTx;
  logic               w_wrStatus;
  logic               w_wrTimer;
  logic [3:0]         w_laneEn;
  logic [31:0]        w_laneData;
  logic               w_txFull;
  logic               w_txBusy;
  logic [c_CNT_W-1:0] w_txCount;
  logic [31:0]        w_status;
  logic [31:0]        w_unusedAddr;

  assign w_unusedAddr = bus.ALUResultM;

  assign w_isMmio   = (bus.ALUResultM[31] == MMIO_BASE[31]);
  assign w_off      = bus.ALUResultM[3:0];
  assign w_idx      = bus.ALUResultM[c_IDX_W+1:2];
  assign w_wrRam    = bus.MemWriteM && !w_isMmio;
  assign w_wrTx     = bus.MemWriteM && w_isMmio && (w_off == OFF_TXDATA);
  assign w_wrStatus = bus.MemWriteM && w_isMmio && (w_off == OFF_STATUS);
  assign w_wrTimer  = bus.MemWriteM && w_isMmio && (w_off == OFF_TIMER);
  assign w_laneEn   = laneMask(bus.InstrM, bus.ALUResultM[1:0]);

  // Replicate the store data so each enabled lane just picks its own byte slot.
  always_comb begin
    case (bus.InstrM)
      SZ_BYTE: w_laneData = {4{bus.WriteDataM[7:0]}};
      SZ_HALF: w_laneData = {2{bus.WriteDataM[15:0]}};
      default: w_laneData = bus.WriteDataM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wrRam) begin
      for (int i = 0; i < 4; i++) begin
        if (w_laneEn[i]) begin
          r_ram[w_idx][8*i +: 8] <= w_laneData[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_timer <= w_wrTimer ? bus.WriteDataM : r_timer + 32'd1;
      // A STATUS write clears the flag even if an overflow is reported the same cycle.
      if (w_wrStatus) begin
        r_ovf <= 1'b0;
      end else if (w_wrTx && w_txFull) begin
        r_ovf <= 1'b1;
      end
    end
  end

  uart_tx_unit #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .TXFIFO_DEPTH (TXFIFO_DEPTH)
  ) u_uart (
    .clk   (clk),
    .reset (reset),
    .push  (w_wrTx),
    .din   (bus.WriteDataM[7:0]),
    .full  (w_txFull),
    .count (w_txCount),
    .busy  (w_txBusy),
    .tx    (uart_tx)
  );

  always_comb begin
    w_status                   = '0;
    w_status[STAT_FULL]        = w_txFull;
    w_status[STAT_BUSY]        = w_txBusy;
    w_status[STAT_OVF]         = r_ovf;
    w_status[STAT_COUNT +: 4]  = 4'(w_txCount);
  end

  always_comb begin
    bus.ReadDataM = '0;
    if (!w_isMmio) begin
      bus.ReadDataM = r_ram[w_idx];
    end else begin
      case (w_off)
        OFF_STATUS: bus.ReadDataM = w_status;
        OFF_TIMER:  bus.ReadDataM = r_timer;
        default:    bus.ReadDataM = '0;
      endcase
    end
  end

endmodule
`default_nettype wire
